// File: rtl/sobel_window_gen_pkg.sv
// Shared constants and types for the Sobel window generator.
package sobel_window_gen_pkg;

  localparam int IMG_WIDTH_DEF       = 32;
  localparam int PIXEL_WIDTH_IN_DEF  = 8;
  // One extra bit so the zero-extended pixel is always non-negative downstream.
  localparam int PIXEL_WIDTH_OUT_DEF = PIXEL_WIDTH_IN_DEF + 1;
  localparam int COL_WIDTH           = $clog2(IMG_WIDTH_DEF);

  // The row counter only needs to distinguish rows 0, 1 and "2 or later".
  localparam int                   ROW_WIDTH = 2;
  localparam logic [ROW_WIDTH-1:0] ROW_LAST  = 2'd2;
  localparam logic [ROW_WIDTH-1:0] ROW_ONE   = 2'd1;

  typedef logic [PIXEL_WIDTH_IN_DEF-1:0] pixel_in_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage: combinational read, clocked write at the same
// address, so a read in the write cycle returns the previous row's pixel.
module sobel_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Contents are never cleared; stale data is masked by row gating upstream.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window generator feeding sobel_core.
// Optional build macro SOBEL_WIN_OUT_REG_EN adds one output register stage
// (latency 2 instead of 1).
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH       = sobel_window_gen_pkg::IMG_WIDTH_DEF,
  parameter int PIXEL_WIDTH_IN  = sobel_window_gen_pkg::PIXEL_WIDTH_IN_DEF,
  parameter int PIXEL_WIDTH_OUT = sobel_window_gen_pkg::PIXEL_WIDTH_OUT_DEF
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       in_valid_i,
  input  logic                       in_sof_i,
  input  logic [PIXEL_WIDTH_IN-1:0]  in_pixel_i,
  output logic                       out_valid_o,
  output logic                       out_eol_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix0_0_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix0_1_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix0_2_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix1_0_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix1_1_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix1_2_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix2_0_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix2_1_o,
  output logic [PIXEL_WIDTH_OUT-1:0] pix2_2_o
);

  localparam int               COL_W    = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  function automatic logic [PIXEL_WIDTH_OUT-1:0] zext(input logic [PIXEL_WIDTH_IN-1:0] p);
    logic [PIXEL_WIDTH_OUT-1:0] z;
    z = '0;
    z[PIXEL_WIDTH_IN-1:0] = p;
    return z;
  endfunction

  logic [COL_W-1:0]          col_q, col_d, eff_col;
  logic [ROW_WIDTH-1:0]      row_q, row_d, eff_row;
  logic                      valid_q, valid_d, eol_q, eol_d;
  logic [PIXEL_WIDTH_IN-1:0] win_q [3][3];
  logic [PIXEL_WIDTH_IN-1:0] win_d [3][3];
  logic [PIXEL_WIDTH_IN-1:0] lb0_rd, lb1_rd;
  logic [8:0][PIXEL_WIDTH_OUT-1:0] win_ext, out_pix;
  logic                      out_valid, out_eol;

  // sof forces the pixel to (row 0, col 0) whatever the counters hold.
  assign eff_col = in_sof_i ? '0 : col_q;
  assign eff_row = in_sof_i ? '0 : row_q;

  // lb0 holds the row before last, lb1 the previous row.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_IN)) u_lb0 (
    .clk_i   (clk_i),
    .we_i    (in_valid_i),
    .addr_i  (eff_col),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_IN)) u_lb1 (
    .clk_i   (clk_i),
    .we_i    (in_valid_i),
    .addr_i  (eff_col),
    .wdata_i (in_pixel_i),
    .rdata_o (lb1_rd)
  );

  // Column/row counters and window qualification for each accepted pixel.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    if (in_valid_i) begin
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? ROW_LAST : eff_row + ROW_ONE;
      end else begin
        col_d = eff_col + COL_ONE;
        row_d = eff_row;
      end
      valid_d = (eff_row == ROW_LAST) && (eff_col >= COL_TWO);
      eol_d   = valid_d && (eff_col == COL_LAST);
    end
  end

  // Shift the window left and load the new column from the line buffers.
  always_comb begin
    win_d = win_q;
    if (in_valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = in_pixel_i;
    end
  end

  // Counter, window and strobe registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      win_q   <= win_d;
    end
  end

  // Zero-extend the window into a flat bus, index = row*3 + col.
  always_comb begin
    win_ext = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_ext[r*3+c] = zext(win_q[r][c]);
      end
    end
  end

`ifdef SOBEL_WIN_OUT_REG_EN
  logic [8:0][PIXEL_WIDTH_OUT-1:0] out_pix_q;
  logic                            out_valid_q, out_eol_q;

  // Extra retiming stage on every output.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      out_pix_q   <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      out_pix_q   <= win_ext;
      out_valid_q <= valid_q;
      out_eol_q   <= eol_q;
    end
  end

  assign out_pix   = out_pix_q;
  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;
`else
  assign out_pix   = win_ext;
  assign out_valid = valid_q;
  assign out_eol   = eol_q;
`endif

  assign out_valid_o = out_valid;
  assign out_eol_o   = out_eol;
  assign pix0_0_o    = out_pix[0];
  assign pix0_1_o    = out_pix[1];
  assign pix0_2_o    = out_pix[2];
  assign pix1_0_o    = out_pix[3];
  assign pix1_1_o    = out_pix[4];
  assign pix1_2_o    = out_pix[5];
  assign pix2_0_o    = out_pix[6];
  assign pix2_1_o    = out_pix[7];
  assign pix2_2_o    = out_pix[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen with IMG_WIDTH=4.
module tb_sobel_window_gen;

  localparam int W    = 4;
  localparam int PIN  = 8;
  localparam int POUT = 9;
`ifdef SOBEL_WIN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            nreset_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_sof_i = 1'b0;
  logic [PIN-1:0]  in_pixel_i = '0;
  logic            out_valid_o, out_eol_o;
  logic [POUT-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

  sobel_window_gen #(.IMG_WIDTH(W), .PIXEL_WIDTH_IN(PIN), .PIXEL_WIDTH_OUT(POUT)) dut (
    .clk_i(clk), .nreset_i(nreset_i), .in_valid_i(in_valid_i), .in_sof_i(in_sof_i),
    .in_pixel_i(in_pixel_i), .out_valid_o(out_valid_o), .out_eol_o(out_eol_o),
    .pix0_0_o(p00), .pix0_1_o(p01), .pix0_2_o(p02),
    .pix1_0_o(p10), .pix1_1_o(p11), .pix1_2_o(p12),
    .pix2_0_o(p20), .pix2_1_o(p21), .pix2_2_o(p22)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [8:0][7:0] pix;
    logic            eol;
    logic [31:0]     cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  // Reference model: the frame as a plain 2D image indexed by (row, col).
  int img [64][W];
  int mr = 0;
  int mc = 0;

  always @(posedge clk) cyc++;

  task automatic model_reset();
    mr = 0;
    mc = 0;
    q.delete();
  endtask

  task automatic send_pix(input int p, input bit sof);
    exp_t e;
    in_valid_i = 1'b1;
    in_sof_i   = sof;
    in_pixel_i = p[7:0];
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    if (mr < 64) img[mr][mc] = p;
    if (mr >= 2 && mr < 64 && mc >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.pix[r*3+c] = img[mr-2+r][mc-2+c][7:0];
      e.eol = (mc == W - 1);
      e.cyc = cyc + LAT;
      q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
    in_pixel_i = 8'($urandom);
  endtask

  // Idle cycles also wiggle sof and pixel, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      in_valid_i = 1'b0;
      in_sof_i   = 1'($urandom);
      in_pixel_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_sof_i = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int npix, input int gap_pct,
                            input bit rand_pix, input int base, input bit sof);
    int k;
    k = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k < npix) begin
          if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3, 1)));
          send_pix(rand_pix ? int'($urandom_range(255)) : base + 10*r + c,
                   sof && (r == 0) && (c == 0));
        end
        k++;
      end
    end
  endtask

  // Monitor
  logic [80:0] dut_bus, prev_bus;
  logic [1:0]  acc_hist = '0;
  int          since_rst = 0;
  int          win_seen = 0;
  exp_t        mon_e;
  logic        hist_bit;

  assign dut_bus = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

  always @(posedge clk) begin
    acc_hist = {acc_hist[0], in_valid_i};
    if (!nreset_i) since_rst = 0;
    else since_rst++;
  end

  always @(negedge clk) begin
    if (!nreset_i) begin
      check("reset_outputs", {dut_bus, out_valid_o, out_eol_o}, '0);
    end else begin
      if (out_valid_o) begin
        win_seen++;
        if (q.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("pix0_0", p00, {1'b0, mon_e.pix[0]});
          check("pix0_1", p01, {1'b0, mon_e.pix[1]});
          check("pix0_2", p02, {1'b0, mon_e.pix[2]});
          check("pix1_0", p10, {1'b0, mon_e.pix[3]});
          check("pix1_1", p11, {1'b0, mon_e.pix[4]});
          check("pix1_2", p12, {1'b0, mon_e.pix[5]});
          check("pix2_0", p20, {1'b0, mon_e.pix[6]});
          check("pix2_1", p21, {1'b0, mon_e.pix[7]});
          check("pix2_2", p22, {1'b0, mon_e.pix[8]});
          check("eol", out_eol_o, mon_e.eol);
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("eol_without_valid", out_eol_o, 0);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          check("missing_window_cycle", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
      hist_bit = (LAT == 1) ? acc_hist[0] : acc_hist[1];
      if (!hist_bit && since_rst >= 3) begin
        check("idle_hold", dut_bus, prev_bus);
        check("idle_valid", out_valid_o, 0);
      end
    end
    prev_bus = dut_bus;
  end

  int w0;
  int nrows;

  initial begin
    // Reset held low with random inputs.
    repeat (6) begin
      in_valid_i = 1'($urandom);
      in_sof_i   = 1'($urandom);
      in_pixel_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
    model_reset();
    nreset_i = 1'b1;
    idle(2);

    // 4x3 frame, no gaps.
    w0 = win_seen;
    send_frame(3, 3*W, 0, 1'b0, 0, 1'b1);
    idle(LAT + 2);
    check("win_count_4x3", win_seen - w0, 2);

    // Same frame with random gaps.
    w0 = win_seen;
    send_frame(3, 3*W, 50, 1'b0, 0, 1'b1);
    idle(LAT + 2);
    check("win_count_4x3_gaps", win_seen - w0, 2);

    // 4x5 frame.
    w0 = win_seen;
    send_frame(5, 5*W, 0, 1'b0, 0, 1'b1);
    idle(LAT + 2);
    check("win_count_4x5", win_seen - w0, 6);

    // Frame cut short by sof after 6 pixels; new frame uses distinct values.
    w0 = win_seen;
    send_frame(3, 6, 0, 1'b0, 0, 1'b1);
    send_frame(3, 3*W, 0, 1'b0, 100, 1'b1);
    idle(LAT + 2);
    check("win_count_sof_restart", win_seen - w0, 2);

    // Reset pulse mid-row 2, then a frame with no sof relies on reset counters.
    send_frame(3, 2*W + 2, 0, 1'b0, 0, 1'b1);
    #1;
    nreset_i = 1'b0;
    model_reset();
    #1;
    check("async_reset_immediate", {dut_bus, out_valid_o, out_eol_o}, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset_i = 1'b1;
    w0 = win_seen;
    send_frame(3, 3*W, 0, 1'b0, 50, 1'b0);
    idle(LAT + 2);
    check("win_count_after_reset", win_seen - w0, 2);

    // Randomized frames: random heights, random truncation, random pixels and gaps.
    for (int f = 0; f < 25; f++) begin
      nrows = int'($urandom_range(6, 1));
      send_frame(nrows, nrows*W - int'($urandom_range(W-1, 0)), 30, 1'b1, 0, 1'b1);
    end

    idle(LAT + 3);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
    $fatal(1);
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

- Converts a raster-order grayscale pixel stream into 3x3 neighbourhood windows for sobel_core.
- Buffers the two previous image rows in line buffers and keeps a 3x3 register window.
- Qualifies each window with a valid strobe.
- Sits between the pixel input interface and the gradient datapath.

## Interface
Parameters:
- IMG_WIDTH, 32: pixels per row; minimum 3.
- PIXEL_WIDTH_IN, 8: width of incoming unsigned pixel.
- PIXEL_WIDTH_OUT, from shared parameters: window pixel width; must be ≥ PIXEL_WIDTH_IN.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- nreset_i  in  1  async active-low reset
- in_valid_i  in  1  pixel qualifier; no backpressure
- in_sof_i  in  1  start-of-frame; sampled only with in_valid_i
- in_pixel_i  in  PIXEL_WIDTH_IN  pixel, raster order
- out_valid_o  out  1  window valid, one cycle per window
- out_eol_o  out  1  asserted with the last valid window of a row
- pix{r}_{c}_o  out  PIXEL_WIDTH_OUT, r,c ∈ {0,1,2} (nine ports)
  - row 0 = oldest line (top), row 2 = current line.
  - col 0 = leftmost, col 2 = newest pixel.

## Operation
- Counters:
  - col: 0..IMG_WIDTH-1, wraps to 0.
  - row: 0..2, saturating; increments on col wrap.
- Accepted pixel (in_valid_i=1):
  - If in_sof_i=1, the pixel is treated as (row 0, col 0) regardless of counter state.
- Line buffers lb1 (previous row) and lb0 (row before that), IMG_WIDTH entries each, read-before-write at index col:
  - lb0[col] ← lb1[col]
  - lb1[col] ← in_pixel_i
- Window shift per accepted pixel, for each r: pix{r}_0 ← pix{r}_1, pix{r}_1 ← pix{r}_2.
- New column:
  - pix2_2 ← in_pixel_i
  - pix1_2 ← old lb1[col]
  - pix0_2 ← old lb0[col]
- Zero-extension: pixels are unsigned, zero-extended to PIXEL_WIDTH_OUT so the top bit is always 0 for the signed consumer.
- Window validity:
  - out_valid_o is set iff the accepted pixel had effective row==2 and col≥2; window centre is (row-1, col-1).
  - Gives IMG_WIDTH-2 windows per row from the third row of a frame onward.
- out_eol_o: asserted with out_valid_o when the accepted pixel had col==IMG_WIDTH-1.
- Frame height is unknown; the next in_sof_i restarts the counters.
- Idle cycles (in_valid_i=0):
  - Window registers and counters hold.
  - out_valid_o and out_eol_o are 0.
- Line buffer contents are not cleared on sof or reset; stale data is masked by the row gating.

## Timing
- Reset values:
  - all window outputs, out_valid_o and out_eol_o: 0
  - col=0, row=0
- Reset assertion takes effect immediately, including mid-row. After release, two full rows are required before the first window.
- Latency: 1 cycle from accepted pixel to out_valid_o and updated pix*_o (all registered, same edge).
- Back-to-back input gives back-to-back windows; there is no throughput loss.
- Simultaneous in_sof_i with col wrap: in_sof_i wins, and row=0 is used for that pixel.
- in_sof_i without in_valid_i: ignored.

## Configuration
- SOBEL_WIN_OUT_REG_EN:
  - Defined: one extra output register stage on pix*_o, out_valid_o and out_eol_o. Latency becomes 2 cycles and all relationships are unchanged. The extra stage resets to 0.
  - Undefined: latency is 1 cycle.

## Structure
- Shared parameters include:
  - IMG_WIDTH default and PIXEL_WIDTH_IN
  - counter width constant COL_WIDTH = $clog2(IMG_WIDTH)
  - typedef pixel_in_t
- Sub-module sobel_line_buffer: one IMG_WIDTH x PIXEL_WIDTH_IN single-port read-before-write buffer, instantiated twice (lb0, lb1).
- Counters, window registers and the optional output stage stay in the top module.

## Test plan
All scenarios use IMG_WIDTH=4 and pixel = 10*row+col unless stated.
- Reset: hold nreset_i low with random inputs -> all outputs 0; out_valid_o never asserts.
- 4x3 frame, sof on the first pixel, no gaps -> exactly 2 out_valid_o pulses, 1 cycle after pixels (2,2) and (2,3).
  - First window: pix0=0,1,2; pix1=10,11,12; pix2=20,21,22.
  - Second window: pix0_0=1 ... pix2_2=23, with out_eol_o=1.
- Same frame with random in_valid_i gaps -> identical window sequence and count; outputs hold during gaps.
- 4x5 frame -> 6 windows; the first row-4 window has pix0_0=20 and pix2_2=42; out_eol_o on every second window.
- sof after 6 pixels -> no window until row 2, col 2 of the new frame. The first window contains only new-frame values.
- nreset_i pulse mid-row 2 -> outputs 0 immediately; the restarted frame yields first valid after row 2, col 2.
  - With SOBEL_WIN_OUT_REG_EN defined, every check above is shifted by one extra cycle.
